// File: rtl/id_issue_buffer.sv
// id_issue_buffer
//   Decode-to-issue buffer: a DEPTH-entry circular FIFO of decoded entries
//   that sits between the decoder and the issue stage. It decouples decode
//   from issue stalls, reports its occupancy, and limits how many
//   control-flow entries may be resident at once (MAX_CF).
//
// Handshake: both sides use valid/ready semantics. An input transfer happens
// in a cycle where in_valid_i && in_ready_o. in_ready_o depends on flush_i,
// in_ctrl_flow_i and out_ack_i in the same cycle, but never on in_valid_i.
// An output transfer happens in a cycle where out_valid_o && out_ack_i. An
// ack while empty does nothing. out_valid_o does not depend on out_ack_i.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   flush_i           discard all entries (no push accepted this cycle)
//   in_valid_i        decoded entry valid
//   in_ready_o        buffer accepts the entry this cycle
//   in_entry_i        decoded entry payload
//   in_ctrl_flow_i    entry is a control-flow instruction
//   out_valid_o       head entry valid
//   out_entry_o       head entry payload (registered storage)
//   out_ctrl_flow_o   head entry is control flow
//   out_ack_i         issue stage consumes the head this cycle
//   usage_o           number of valid entries
//   cf_count_o        number of valid control-flow entries
module id_issue_buffer #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned ENTRY_W = 64,
  parameter int unsigned MAX_CF  = 1,
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [ENTRY_W-1:0] in_entry_i,
  input  logic               in_ctrl_flow_i,
  output logic               out_valid_o,
  output logic [ENTRY_W-1:0] out_entry_o,
  output logic               out_ctrl_flow_o,
  input  logic               out_ack_i,
  output logic [CNT_W-1:0]   usage_o,
  output logic [CNT_W-1:0]   cf_count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_CF_C = CNT_W'(MAX_CF);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  logic [ENTRY_W-1:0] entry_q [DEPTH];
  logic               cf_q    [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   usage_q, cf_count_q;

  logic pop, pop_cf, push, push_cf, space, cf_ok;

  assign out_valid_o     = (usage_q != '0);
  assign out_entry_o     = entry_q[rd_ptr_q];
  assign out_ctrl_flow_o = cf_q[rd_ptr_q];

  assign pop     = out_ack_i && out_valid_o;
  assign pop_cf  = pop && out_ctrl_flow_o;
  // A pop frees its slot (and its control-flow credit) in the same cycle.
  assign space   = (usage_q < DEPTH_C) || pop;
  assign cf_ok   = !in_ctrl_flow_i || (cf_count_q < MAX_CF_C) || pop_cf;
  assign in_ready_o = !flush_i && space && cf_ok;
  assign push    = in_valid_i && in_ready_o;
  assign push_cf = push && in_ctrl_flow_i;

  assign usage_o    = usage_q;
  assign cf_count_o = cf_count_q;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      usage_q    <= '0;
      cf_count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        entry_q[i] <= '0;
        cf_q[i]    <= 1'b0;
      end
    end else if (flush_i) begin
      // Storage is left as is; usage of zero masks the stale slots.
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      usage_q    <= '0;
      cf_count_q <= '0;
    end else begin
      if (push) begin
        entry_q[wr_ptr_q] <= in_entry_i;
        cf_q[wr_ptr_q]    <= in_ctrl_flow_i;
        wr_ptr_q          <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      if (push && !pop) begin
        usage_q <= usage_q + ONE_C;
      end else if (pop && !push) begin
        usage_q <= usage_q - ONE_C;
      end
      if (push_cf && !pop_cf) begin
        cf_count_q <= cf_count_q + ONE_C;
      end else if (pop_cf && !push_cf) begin
        cf_count_q <= cf_count_q - ONE_C;
      end
    end
  end

endmodule

// File: tb/tb_id_issue_buffer.sv
// Directed testbench for id_issue_buffer (DEPTH=4, ENTRY_W=16, MAX_CF=1).
// Inputs change 1 time unit after the rising edge; outputs are sampled a
// further time unit later, well away from the next edge.
module tb_id_issue_buffer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned ENTRY_W = 16;
  localparam int unsigned MAX_CF  = 1;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               flush_i;
  logic               in_valid_i;
  logic               in_ready_o;
  logic [ENTRY_W-1:0] in_entry_i;
  logic               in_ctrl_flow_i;
  logic               out_valid_o;
  logic [ENTRY_W-1:0] out_entry_o;
  logic               out_ctrl_flow_o;
  logic               out_ack_i;
  logic [CNT_W-1:0]   usage_o;
  logic [CNT_W-1:0]   cf_count_o;

  int checks = 0;
  int errors = 0;

  id_issue_buffer #(.DEPTH(DEPTH), .ENTRY_W(ENTRY_W), .MAX_CF(MAX_CF)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_entry_i(in_entry_i),
    .in_ctrl_flow_i(in_ctrl_flow_i), .out_valid_o(out_valid_o),
    .out_entry_o(out_entry_o), .out_ctrl_flow_o(out_ctrl_flow_o),
    .out_ack_i(out_ack_i), .usage_o(usage_o), .cf_count_o(cf_count_o)
  );

  // clock
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive one cycle's inputs (just after an edge) and let them settle.
  task automatic drive(input logic v, input logic [ENTRY_W-1:0] e, input logic cf,
                       input logic ack, input logic fl);
    in_valid_i     = v;
    in_entry_i     = e;
    in_ctrl_flow_i = cf;
    out_ack_i      = ack;
    flush_i        = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Push one entry with no ack; the entry must be accepted.
  task automatic push(input logic [ENTRY_W-1:0] e, input logic cf);
    drive(1'b1, e, cf, 1'b0, 1'b0);
    check("push_ready", 32'(in_ready_o), 32'd1);
    tick();
  endtask

  initial begin
    // reset block
    rst_ni = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #3;
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_entry", 32'(out_entry_o), 32'd0);
    check("rst_cf_out", 32'(out_ctrl_flow_o), 32'd0);
    check("rst_usage", 32'(usage_o), 32'd0);
    check("rst_cf_count", 32'(cf_count_o), 32'd0);
    #10 rst_ni = 1'b1;
    tick();

    // Fill to DEPTH with A..D, E must stall.
    push(16'h00A0, 1'b0);
    check("latency_head_a", 32'(out_entry_o), 32'h00A0);
    check("latency_valid", 32'(out_valid_o), 32'd1);
    push(16'h00B0, 1'b0);
    push(16'h00C0, 1'b0);
    push(16'h00D0, 1'b0);
    check("full_usage", 32'(usage_o), 32'd4);
    check("full_head_a", 32'(out_entry_o), 32'h00A0);
    drive(1'b1, 16'h00E0, 1'b0, 1'b0, 1'b0);
    check("full_ready_e", 32'(in_ready_o), 32'd0);
    tick();
    check("full_usage_hold", 32'(usage_o), 32'd4);
    check("full_head_hold", 32'(out_entry_o), 32'h00A0);

    // Push E with a simultaneous pop while full.
    drive(1'b1, 16'h00E0, 1'b0, 1'b1, 1'b0);
    check("full_pop_ready", 32'(in_ready_o), 32'd1);
    tick();
    check("full_pop_usage", 32'(usage_o), 32'd4);
    check("full_pop_head", 32'(out_entry_o), 32'h00B0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("drain_b", 32'(out_entry_o), 32'h00B0);
    tick();
    check("drain_c", 32'(out_entry_o), 32'h00C0);
    tick();
    check("drain_d", 32'(out_entry_o), 32'h00D0);
    tick();
    check("drain_e", 32'(out_entry_o), 32'h00E0);
    check("drain_usage1", 32'(usage_o), 32'd1);
    tick();
    check("drain_usage0", 32'(usage_o), 32'd0);
    check("drain_valid0", 32'(out_valid_o), 32'd0);

    // Control-flow throttle with MAX_CF=1.
    push(16'h0C01, 1'b1);
    check("cf_count_x", 32'(cf_count_o), 32'd1);
    check("cf_head_flag", 32'(out_ctrl_flow_o), 32'd1);
    drive(1'b1, 16'h0C02, 1'b1, 1'b0, 1'b0);
    check("cf_stall_ready", 32'(in_ready_o), 32'd0);
    tick();
    check("cf_stall_count", 32'(cf_count_o), 32'd1);
    check("cf_stall_usage", 32'(usage_o), 32'd1);
    drive(1'b1, 16'h0C02, 1'b1, 1'b1, 1'b0);
    check("cf_swap_ready", 32'(in_ready_o), 32'd1);
    tick();
    check("cf_swap_count", 32'(cf_count_o), 32'd1);
    check("cf_swap_usage", 32'(usage_o), 32'd1);
    check("cf_swap_head", 32'(out_entry_o), 32'h0C02);
    // A non-cf entry is not throttled while cf_count is at its limit.
    drive(1'b1, 16'h0C03, 1'b0, 1'b0, 1'b0);
    check("cf_plain_ready", 32'(in_ready_o), 32'd1);
    tick();
    check("cf_plain_usage", 32'(usage_o), 32'd2);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    check("cf_pop_count", 32'(cf_count_o), 32'd0);
    check("cf_pop_head", 32'(out_entry_o), 32'h0C03);
    tick();
    check("cf_empty", 32'(usage_o), 32'd0);

    // Flush with three entries and a push attempt.
    push(16'h0F01, 1'b0);
    push(16'h0F02, 1'b0);
    push(16'h0F03, 1'b1);
    check("pre_flush_usage", 32'(usage_o), 32'd3);
    check("pre_flush_cf", 32'(cf_count_o), 32'd1);
    drive(1'b1, 16'h0F04, 1'b0, 1'b0, 1'b1);
    check("flush_ready", 32'(in_ready_o), 32'd0);
    tick();
    check("flush_usage", 32'(usage_o), 32'd0);
    check("flush_cf", 32'(cf_count_o), 32'd0);
    check("flush_valid", 32'(out_valid_o), 32'd0);
    drive(1'b1, 16'h0F05, 1'b0, 1'b0, 1'b0);
    check("post_flush_ready", 32'(in_ready_o), 32'd1);
    check("post_flush_not_yet", 32'(out_valid_o), 32'd0);
    tick();
    check("post_flush_valid", 32'(out_valid_o), 32'd1);
    check("post_flush_head", 32'(out_entry_o), 32'h0F05);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    check("post_flush_empty", 32'(usage_o), 32'd0);

    // Ack while empty is ignored.
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    tick();
    check("empty_ack_usage", 32'(usage_o), 32'd0);
    check("empty_ack_valid", 32'(out_valid_o), 32'd0);
    push(16'h0071, 1'b0);
    check("one_head_t", 32'(out_entry_o), 32'h0071);
    drive(1'b1, 16'h0072, 1'b0, 1'b1, 1'b0);
    check("one_swap_ready", 32'(in_ready_o), 32'd1);
    tick();
    check("one_swap_usage", 32'(usage_o), 32'd1);
    check("one_swap_head", 32'(out_entry_o), 32'h0072);

    // Asynchronous reset while holding three entries.
    push(16'h0081, 1'b1);
    push(16'h0082, 1'b0);
    idle();
    check("pre_rst_usage", 32'(usage_o), 32'd3);
    check("pre_rst_cf", 32'(cf_count_o), 32'd1);
    #1 rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid_o), 32'd0);
    check("mid_rst_entry", 32'(out_entry_o), 32'd0);
    check("mid_rst_usage", 32'(usage_o), 32'd0);
    check("mid_rst_cf", 32'(cf_count_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready_o), 32'd1);
    tick();
    check("post_rst_usage", 32'(usage_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
